// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch (port 0) vs load/store (port 1) onto a byte-wide sync RAM, little-endian reassembly.
// Latency: read of N bytes done in cycle N+2 after accept, write in cycle N+1; misaligned (MEM_CTRL_MISALIGN_CHK_EN) in cycle 1.
// Backpressure: level requests held until done_o; port 1 wins; if_flush aborts a port-0 read via a one-cycle DRAIN.
module mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_re,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    input  logic              ls_re,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [1:0]        ls_width,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        busy_o,
    output logic [1:0]        done_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] wbuf;
    logic [DATA_W-1:0] asm_q;
    logic [DATA_W-1:0] asm_next;
    logic [2:0]        nbytes;
    logic [2:0]        cnt;
    logic              port;

    logic              req_any;
    logic              acc_port;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [2:0]        acc_n;
    logic              misalign;
    logic              flush_hit;
    logic              issue_more;
    logic              rd_last;
    logic [ADDR_W-1:0] next_addr;
    logic [1:0]        cap_idx;

    always_comb begin
        req_any   = if_re | ls_re | ls_we;
        acc_port  = ls_re | ls_we;
        acc_write = ls_we;
        acc_addr  = acc_port ? ls_addr : if_addr;
        acc_n     = 3'd4;
        if (acc_port) begin
            case (ls_width)
                2'd0:    acc_n = 3'd1;
                2'd1:    acc_n = 3'd2;
                default: acc_n = 3'd4;
            endcase
        end
        misalign = 1'b0;
`ifdef MEM_CTRL_MISALIGN_CHK_EN
        misalign = ((acc_n == 3'd2) && acc_addr[0]) ||
                   ((acc_n == 3'd4) && (acc_addr[1:0] != 2'b00));
`endif
        flush_hit  = (state == READ) && !port && if_flush;
        issue_more = (cnt < (nbytes - 3'd1));
        rd_last    = (cnt == nbytes);
        next_addr  = base + ADDR_W'(cnt) + ADDR_W'(1);
        // cnt runs one ahead of the byte being captured because the RAM is synchronous
        cap_idx    = 2'(cnt - 3'd1);
        asm_next   = asm_q;
        asm_next[{cap_idx, 3'b000} +: 8] = ram_rdata;

        next_state = state;
        case (state)
            IDLE:    if (req_any && !misalign) next_state = acc_write ? WRITE : READ;
            READ:    if (flush_hit) next_state = DRAIN;
                     else if (rd_last) next_state = IDLE;
            WRITE:   if (!issue_more) next_state = IDLE;
            DRAIN:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base      <= '0;
            wbuf      <= '0;
            asm_q     <= '0;
            nbytes    <= '0;
            cnt       <= '0;
            port      <= 1'b0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            rdata_o   <= '0;
            busy_o    <= 2'b00;
            done_o    <= 2'b00;
        end else begin
            done_o <= 2'b00;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        if (misalign) begin
                            done_o <= acc_port ? 2'b10 : 2'b01;
                        end else begin
                            base      <= acc_addr;
                            nbytes    <= acc_n;
                            port      <= acc_port;
                            cnt       <= '0;
                            asm_q     <= '0;
                            wbuf      <= ls_wdata;
                            ram_addr  <= acc_addr;
                            ram_we    <= acc_write;
                            ram_wdata <= ls_wdata[7:0];
                            busy_o    <= acc_port ? 2'b10 : 2'b01;
                        end
                    end
                end
                READ: begin
                    if (!flush_hit) begin
                        cnt <= cnt + 3'd1;
                        if (issue_more)  ram_addr <= next_addr;
                        if (cnt != 3'd0) asm_q    <= asm_next;
                        if (rd_last) begin
                            rdata_o <= asm_next;
                            done_o  <= port ? 2'b10 : 2'b01;
                            busy_o  <= 2'b00;
                        end
                    end
                end
                WRITE: begin
                    if (issue_more) begin
                        cnt       <= cnt + 3'd1;
                        ram_addr  <= next_addr;
                        ram_wdata <= wbuf[15:8];
                        wbuf      <= wbuf >> 8;
                    end else begin
                        ram_we <= 1'b0;
                        done_o <= port ? 2'b10 : 2'b01;
                        busy_o <= 2'b00;
                    end
                end
                DRAIN:   busy_o <= 2'b00;
                default: ;
            endcase
        end
    end

`ifdef MEM_CTRL_MISALIGN_CHK_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= (state == IDLE) && req_any && misalign;
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboarded bench for mem_ctrl: directed transactions push expected done/write events, monitors pop and compare.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_re, if_flush, ls_re, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [1:0]  ls_width;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic [31:0] rdata_o;
    logic [1:0]  busy_o, done_o;
    logic        err_o;

    mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_re(if_re), .if_addr(if_addr), .if_flush(if_flush),
        .ls_re(ls_re), .ls_we(ls_we), .ls_addr(ls_addr), .ls_width(ls_width), .ls_wdata(ls_wdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .rdata_o(rdata_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int t0  = 0;
    int n_tests = 0;
    int n_fail  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic [1:0] done; logic [31:0] rdata; logic err; } exp_t;
    typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_t;
    exp_t eq[$];
    wr_t  wq[$];
    exp_t me;
    wr_t  mw;

    // RAM: fixed preload contents overlaid by bytes written through the DUT
    logic [7:0] wr_mem [0:4095];
    bit         wr_vld [0:4095];

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h10: return 8'h13;  32'h11: return 8'h05;  32'h12: return 8'h50;  32'h13: return 8'h00;
            32'h20: return 8'h11;  32'h21: return 8'h22;  32'h22: return 8'h33;  32'h23: return 8'h44;
            32'h200: return 8'h34; 32'h201: return 8'h12; 32'h202: return 8'h56;
            32'hFFFFFFFE: return 8'hA1; 32'hFFFFFFFF: return 8'hB2;
            32'h0: return 8'hC3;   32'h1: return 8'hD4;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        ram_rdata <= wr_vld[ram_addr[11:0]] ? wr_mem[ram_addr[11:0]] : rom(ram_addr);
        if (ram_we) begin
            wr_mem[ram_addr[11:0]] <= ram_wdata;
            wr_vld[ram_addr[11:0]] <= 1'b1;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done_o != 2'b00) begin
            if (eq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_done: got done_o=%b, expected none", done_o);
            end else begin
                me = eq.pop_front();
                check("done_port", {62'd0, done_o}, {62'd0, me.done});
                check("rdata", {32'd0, rdata_o}, {32'd0, me.rdata});
                check("err", {63'd0, err_o}, {63'd0, me.err});
            end
        end
        if (rst_n && ram_we) begin
            if (wq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected none", ram_addr, ram_wdata);
            end else begin
                mw = wq.pop_front();
                check("wr_addr", {32'd0, ram_addr}, {32'd0, mw.a});
                check("wr_data", {56'd0, ram_wdata}, {56'd0, mw.d});
            end
        end
    end

    task automatic fetch(input logic [31:0] a);
        @(negedge clk);
        if_addr = a; if_re = 1'b1; t0 = cyc;
    endtask

    task automatic ls_read(input logic [31:0] a, input logic [1:0] w);
        @(negedge clk);
        ls_addr = a; ls_width = w; ls_re = 1'b1; t0 = cyc;
    endtask

    task automatic ls_write(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
        @(negedge clk);
        ls_addr = a; ls_width = w; ls_wdata = d; ls_we = 1'b1; t0 = cyc;
    endtask

    task automatic wait_done(input int exp_c, input string nm);
        int c = 0;
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done_o != 2'b00) begin
                got = 1'b1;
                c = cyc - t0;
            end
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL %s: got no done within 40 cycles, expected cycle %0d", nm, exp_c);
        end else begin
            check(nm, 64'(c), 64'(exp_c));
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_ram_addr"}, {32'd0, ram_addr}, 64'd0);
        check({nm, "_ram_we"}, {63'd0, ram_we}, 64'd0);
        check({nm, "_ram_wdata"}, {56'd0, ram_wdata}, 64'd0);
        check({nm, "_rdata"}, {32'd0, rdata_o}, 64'd0);
        check({nm, "_busy"}, {62'd0, busy_o}, 64'd0);
        check({nm, "_done"}, {62'd0, done_o}, 64'd0);
        check({nm, "_err"}, {63'd0, err_o}, 64'd0);
    endtask

    logic [31:0] last_rd;
    logic [31:0] wa [4];

    initial begin
        if_re = 1'b0; if_addr = '0; if_flush = 1'b0;
        ls_re = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_width = '0; ls_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // word fetch at 0x10
        last_rd = 32'h00500513;
        eq.push_back({2'b01, last_rd, 1'b0});
        fetch(32'h10);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("fetch_addr", {32'd0, ram_addr}, 64'(32'h10 + k));
            check("fetch_busy", {62'd0, busy_o}, 64'd1);
        end
        wait_done(6, "fetch_done_cycle");
        check("fetch_busy_done", {62'd0, busy_o}, 64'd0);
        if_re = 1'b0;

        // byte store leaves rdata_o alone
        wq.push_back({32'h103, 8'hDD});
        eq.push_back({2'b10, last_rd, 1'b0});
        ls_write(32'h103, 2'd0, 32'hAABBCCDD);
        wait_done(2, "store_byte_cycle");
        ls_we = 1'b0;

        // simultaneous requests: port 1 half read first, then fetch back-to-back
        eq.push_back({2'b10, 32'h00001234, 1'b0});
        eq.push_back({2'b01, 32'h44332211, 1'b0});
        last_rd = 32'h44332211;
        @(negedge clk);
        if_addr = 32'h20; if_re = 1'b1;
        ls_addr = 32'h200; ls_width = 2'd1; ls_re = 1'b1;
        t0 = cyc;
        wait_done(4, "arb_port1_cycle");
        ls_re = 1'b0;
        wait_done(10, "arb_port0_cycle");
        if_re = 1'b0;

        // flush in cycle 2 of a fetch
        fetch(32'h40);
        @(negedge clk);
        check("flush_addr_c1", {32'd0, ram_addr}, 64'h40);
        @(negedge clk);
        check("flush_addr_c2", {32'd0, ram_addr}, 64'h41);
        if_flush = 1'b1; if_re = 1'b0;
        @(negedge clk);
        check("flush_addr_c3", {32'd0, ram_addr}, 64'h41);
        check("flush_busy_c3", {62'd0, busy_o}, 64'd1);
        if_flush = 1'b0;
        @(negedge clk);
        check("flush_addr_c4", {32'd0, ram_addr}, 64'h41);
        check("flush_busy_c4", {62'd0, busy_o}, 64'd0);
        repeat (2) begin
            @(negedge clk);
            check("flush_no_done", {62'd0, done_o}, 64'd0);
        end
        last_rd = 32'h00500513;
        eq.push_back({2'b01, last_rd, 1'b0});
        fetch(32'h10);
        wait_done(6, "refetch_done_cycle");
        if_re = 1'b0;

`ifndef MEM_CTRL_MISALIGN_CHK_EN
        // unaligned word fetch wraps through address 0
        wa = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
        last_rd = 32'hD4C3B2A1;
        eq.push_back({2'b01, last_rd, 1'b0});
        fetch(32'hFFFFFFFE);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("wrap_addr", {32'd0, ram_addr}, {32'd0, wa[k]});
        end
        wait_done(6, "wrap_done_cycle");
        if_re = 1'b0;
        last_rd = 32'h00005612;
        eq.push_back({2'b10, last_rd, 1'b0});
        ls_read(32'h201, 2'd1);
        wait_done(4, "odd_half_cycle");
        ls_re = 1'b0;
`else
        // misaligned accesses rejected in cycle 1 without touching RAM
        eq.push_back({2'b01, last_rd, 1'b1});
        fetch(32'hFFFFFFFE);
        wait_done(1, "misalign_fetch_cycle");
        check("misalign_no_addr", {32'd0, ram_addr}, 64'h13);
        check("misalign_no_busy", {62'd0, busy_o}, 64'd0);
        if_re = 1'b0;
        eq.push_back({2'b10, last_rd, 1'b1});
        ls_read(32'h201, 2'd1);
        wait_done(1, "misalign_half_cycle");
        ls_re = 1'b0;
`endif

        // word store then width-3 read back
        wq.push_back({32'h300, 8'h0D});
        wq.push_back({32'h301, 8'hF0});
        wq.push_back({32'h302, 8'hFE});
        wq.push_back({32'h303, 8'hCA});
        eq.push_back({2'b10, last_rd, 1'b0});
        ls_write(32'h300, 2'd2, 32'hCAFEF00D);
        wait_done(5, "store_word_cycle");
        ls_we = 1'b0;
        eq.push_back({2'b10, 32'hCAFEF00D, 1'b0});
        ls_read(32'h300, 2'd3);
        wait_done(6, "readback_cycle");
        ls_re = 1'b0;

        // reset during cycle 3 of a word store
        wq.push_back({32'h400, 8'h44});
        wq.push_back({32'h401, 8'h33});
        ls_write(32'h400, 2'd2, 32'h11223344);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0; ls_we = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_reset_done", {62'd0, done_o}, 64'd0);
            check("post_reset_busy", {62'd0, busy_o}, 64'd0);
        end

        eq.push_back({2'b01, 32'h00500513, 1'b0});
        fetch(32'h10);
        wait_done(6, "recover_fetch_cycle");
        if_re = 1'b0;

        repeat (2) @(negedge clk);
        check("exp_queue_empty", 64'(eq.size()), 64'd0);
        check("wr_queue_empty", 64'(wq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
